mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning the number of cycles from S_R_req high to S_R_data valid; legal values are 1 to 4.
REQ-004 SHALL provide these ports:
- clk, in, 1: sole clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- Mn_R_req (n=0..2), in, 1: read request from requester n.
- Mn_W_req, in, 4: byte-lane write enables; nonzero means write request.
- Mn_addr, in, ADDR_W: word address.
- Mn_W_data, in, DATA_W: write data.
- Mn_gnt, out, 1: access from requester n is on the S_* bus this cycle.
- Mn_R_valid, out, 1: Mn_R_data holds the read result this cycle.
- Mn_R_data, out, DATA_W: read data.
- Mn_err, out, 1: sticky flag; a read and a write were requested together.
- S_R_req, out, 1: shared SRAM read strobe.
- S_W_req, out, 4: shared SRAM byte write enables.
- S_addr, out, ADDR_W: shared SRAM address.
- S_W_data, out, DATA_W: shared SRAM write data.
- S_R_data, in, DATA_W: shared SRAM read data.
- busy, out, 1: an access is issued or a read is in flight.

Function
REQ-005 SHALL let a requester be eligible at a rising edge when (Mn_R_req or |Mn_W_req) is high and Mn_gnt is low at that edge. A request sampled while its gnt is high is consumed, not re-granted.
REQ-006 SHALL pick at most one eligible requester per edge, using round-robin order. Pointer reset value = 0. After a grant to n, priority order becomes n+1, n+2, n (mod 3).
REQ-007 SHALL register the winner's access onto S_* and assert the winner's Mn_gnt for exactly that one cycle. Grant latency is 1 cycle from the sampling edge.
REQ-008 SHALL drive S_R_req=0, S_W_req=0, S_addr=0 and S_W_data=0 in any cycle with no grant.
REQ-009 SHALL require the requester to hold its address, data and request stable until the gnt cycle. The requester may change them at the edge that ends the gnt cycle.
REQ-010 SHALL treat R_req=1 together with W_req≠0 as a write only (read dropped) and set Mn_err, which stays set until reset.
REQ-011 SHALL track the owner of each in-flight read in an RD_LAT-deep id pipeline. This allows back-to-back grants to different requesters with reads overlapping.
REQ-012 SHALL assert Mn_R_valid exactly RD_LAT cycles after that read's gnt cycle, for one cycle. Mn_R_data SHALL equal S_R_data in that cycle.
REQ-013 SHALL drive Mn_R_data to 0 whenever Mn_R_valid is low.
REQ-014 SHALL allow a write grant in the same cycle that an earlier read's R_valid is returned. No bus turnaround penalty applies.
REQ-015 SHALL assert busy when any gnt is high or any id-pipeline slot is occupied.
REQ-016 SHALL guarantee starvation freedom: a held request is granted within 3 cycles when all three requesters request continuously.

Reset
REQ-017 SHALL, while rst=0, asynchronously force the following to 0: all gnt, R_valid, R_data, err, the S_* outputs, busy, the rotation pointer and the id pipeline.
REQ-018 SHALL discard in-flight reads when reset is asserted mid-operation. No R_valid is generated for them after rst rises.
REQ-019 SHALL make the first grant possible at the second rising edge after rst deasserts.

Structure
REQ-020 SHALL take the requester count (3), the requester-id width (2), the idle id encoding and the RD_LAT bounds from a shared package, accel_mem_pkg.
REQ-021 SHALL place the round-robin pick (3 requests plus pointer in, one-hot grant out, combinational) in one sub-module, rr_pick3.

Verification
REQ-022 SHALL cover: M0 read addr 0x5 only, SRAM returns 0xDEADBEEF with RD_LAT=1. Required: M0_gnt in cycle 1, S_addr=0x5, M0_R_valid in cycle 2 with M0_R_data=0xDEADBEEF.
REQ-023 SHALL cover: all three requesters writing continuously from reset. Required: grant order M0, M1, M2, M0, …; no requester waits more than 3 cycles.
REQ-024 SHALL cover: M1 read and M2 read requested together, RD_LAT=2. Required: M1 granted first, M2 the next cycle; each R_valid routes to the correct requester 2 cycles after its own gnt.
REQ-025 SHALL cover: M2 requests R_req=1 and W_req=4'hF together. Required: S_W_req=4'hF, S_R_req=0, M2_err=1 and sticky, no M2_R_valid.
REQ-026 SHALL cover: rst pulled low one cycle after a read gnt. Required: all outputs 0 immediately, no R_valid after release, first new grant at the second edge after release.
REQ-027 SHALL cover: M0 holds its request high after gnt. Required: no re-grant at the gnt edge; re-grant no earlier than 2 cycles after the first grant.

Source files
------------

// File: rtl/accel_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : accel_mem_pkg
//  Purpose : Shared constants, types and helpers for the shared-SRAM arbiter.
//            Holds the requester count, requester-id encoding (including the
//            "no owner" idle id), read-latency bounds and access classifier.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package accel_mem_pkg;

  localparam int NUM_REQ    = 3;
  localparam int ID_W       = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef logic [ID_W-1:0] req_id_t;

  // Id value marking an empty slot in the read-owner pipeline.
  localparam req_id_t ID_IDLE = 2'd3;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_t;

  // A write strobe always wins: a combined read+write is executed as a write.
  function automatic acc_kind_t classify(input logic rreq, input logic [3:0] wreq);
    if (|wreq)     return ACC_WRITE;
    else if (rreq) return ACC_READ;
    else           return ACC_NONE;
  endfunction

  function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] oh);
    if (oh[0])      return 2'd0;
    else if (oh[1]) return 2'd1;
    else if (oh[2]) return 2'd2;
    else            return ID_IDLE;
  endfunction

  // Rotation pointer value after a grant to requester id.
  function automatic logic [ID_W-1:0] ptr_after(input req_id_t id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage : accel_mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick3.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick3
//  Purpose : Combinational three-way round-robin pick. The pointer names the
//            requester with highest priority; the others follow in ascending
//            order modulo 3.
//  Ports   : req  in  [3]  eligible requests
//            ptr  in  [2]  highest-priority requester (0..2)
//            gnt  out [3]  one-hot winner, all zero when nothing requests
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick3
  import accel_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (ptr)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      // Pointer value 3 never occurs; treat it like 0.
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule : rr_pick3
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter
//  Purpose : Round-robin arbiter sharing one SRAM port between three
//            requesters. One access is issued per cycle; read results are
//            routed back to their owner RD_LAT cycles after the grant via an
//            id pipeline, so reads from different requesters may overlap.
//  Ports   : clk               clock, rising edge
//            rst               asynchronous active-low reset
//            Mn_R_req/W_req    read request / byte write enables (n=0..2)
//            Mn_addr/W_data    word address / write data
//            Mn_gnt            access of requester n is on S_* this cycle
//            Mn_R_valid/R_data read return (data zero when not valid)
//            Mn_err            sticky: read and write requested together
//            S_R_req/W_req/addr/W_data  SRAM command (all zero when idle)
//            S_R_data          SRAM read data
//            busy              grant active or read in flight
//  Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
  import accel_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M0_R_req,
  input  logic [3:0]        M0_W_req,
  input  logic [ADDR_W-1:0] M0_addr,
  input  logic [DATA_W-1:0] M0_W_data,
  output logic              M0_gnt,
  output logic              M0_R_valid,
  output logic [DATA_W-1:0] M0_R_data,
  output logic              M0_err,
  input  logic              M1_R_req,
  input  logic [3:0]        M1_W_req,
  input  logic [ADDR_W-1:0] M1_addr,
  input  logic [DATA_W-1:0] M1_W_data,
  output logic              M1_gnt,
  output logic              M1_R_valid,
  output logic [DATA_W-1:0] M1_R_data,
  output logic              M1_err,
  input  logic              M2_R_req,
  input  logic [3:0]        M2_W_req,
  input  logic [ADDR_W-1:0] M2_addr,
  input  logic [DATA_W-1:0] M2_W_data,
  output logic              M2_gnt,
  output logic              M2_R_valid,
  output logic [DATA_W-1:0] M2_R_data,
  output logic              M2_err,
  output logic              S_R_req,
  output logic [3:0]        S_W_req,
  output logic [ADDR_W-1:0] S_addr,
  output logic [DATA_W-1:0] S_W_data,
  input  logic [DATA_W-1:0] S_R_data,
  output logic              busy
);

  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  // ---------------------------------------------------------------- inputs
  logic [NUM_REQ-1:0] w_rreq;
  logic [3:0]         w_wreq  [NUM_REQ];
  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];

  assign w_rreq     = {M2_R_req, M1_R_req, M0_R_req};
  assign w_wreq[0]  = M0_W_req;
  assign w_wreq[1]  = M1_W_req;
  assign w_wreq[2]  = M2_W_req;
  assign w_addr[0]  = M0_addr;
  assign w_addr[1]  = M1_addr;
  assign w_addr[2]  = M2_addr;
  assign w_wdata[0] = M0_W_data;
  assign w_wdata[1] = M1_W_data;
  assign w_wdata[2] = M2_W_data;

  // ---------------------------------------------------------------- state
  logic               r_en;        // arbitration enabled one edge after reset release
  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_s_rreq;
  logic [3:0]         r_s_wreq;
  logic [ADDR_W-1:0]  r_s_addr;
  logic [DATA_W-1:0]  r_s_wdata;
  req_id_t            r_issue_id;  // read owner of the access on S_* now
  req_id_t            r_pipe [1:LAT];
  logic [NUM_REQ-1:0] r_err;

  // ---------------------------------------------------------------- pick
  logic [NUM_REQ-1:0] w_active;
  logic [NUM_REQ-1:0] w_conflict;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_active[i]   = w_rreq[i] | (|w_wreq[i]);
      w_conflict[i] = w_rreq[i] & (|w_wreq[i]);
    end
  end

  // A request seen while its own grant is high is the one being served now,
  // so it is masked rather than granted a second time.
  assign w_elig = w_active & ~r_gnt & {NUM_REQ{r_en}};

  rr_pick3 u_pick (
    .req (w_elig),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  req_id_t           w_win_id;
  acc_kind_t         w_win_kind;
  logic [3:0]        w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  always_comb begin
    w_win_id    = onehot_to_id(w_pick);
    w_win_kind  = ACC_NONE;
    w_win_we    = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_win_kind  = classify(w_rreq[i], w_wreq[i]);
        w_win_we    = w_wreq[i];
        w_win_addr  = w_addr[i];
        w_win_wdata = w_wdata[i];
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en       <= 1'b0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_s_rreq   <= 1'b0;
      r_s_wreq   <= '0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_issue_id <= ID_IDLE;
      r_err      <= '0;
      for (int k = 1; k <= LAT; k++) r_pipe[k] <= ID_IDLE;
    end else begin
      r_en  <= 1'b1;
      r_gnt <= w_pick;
      r_err <= r_err | (w_pick & w_conflict);

      if (|w_pick) begin
        r_ptr     <= ptr_after(w_win_id);
        r_s_rreq  <= (w_win_kind == ACC_READ);
        r_s_wreq  <= w_win_we;
        r_s_addr  <= w_win_addr;
        r_s_wdata <= (w_win_kind == ACC_WRITE) ? w_win_wdata : '0;
      end else begin
        r_s_rreq  <= 1'b0;
        r_s_wreq  <= '0;
        r_s_addr  <= '0;
        r_s_wdata <= '0;
      end

      r_issue_id <= (w_win_kind == ACC_READ) ? w_win_id : ID_IDLE;
      // Slot k holds the owner of the read granted k cycles ago.
      r_pipe[1] <= r_issue_id;
      for (int k = 2; k <= LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // ---------------------------------------------------------------- returns
  logic [NUM_REQ-1:0] w_rvalid;
  logic               w_busy;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rvalid[i] = (r_pipe[LAT] == req_id_t'(i));
    end
  end

  always_comb begin
    w_busy = |r_gnt;
    for (int k = 1; k <= LAT; k++) begin
      if (r_pipe[k] != ID_IDLE) w_busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign M0_gnt     = r_gnt[0];
  assign M1_gnt     = r_gnt[1];
  assign M2_gnt     = r_gnt[2];
  assign M0_err     = r_err[0];
  assign M1_err     = r_err[1];
  assign M2_err     = r_err[2];
  assign M0_R_valid = w_rvalid[0];
  assign M1_R_valid = w_rvalid[1];
  assign M2_R_valid = w_rvalid[2];
  assign M0_R_data  = w_rvalid[0] ? S_R_data : '0;
  assign M1_R_data  = w_rvalid[1] ? S_R_data : '0;
  assign M2_R_data  = w_rvalid[2] ? S_R_data : '0;
  assign S_R_req    = r_s_rreq;
  assign S_W_req    = r_s_wreq;
  assign S_addr     = r_s_addr;
  assign S_W_data   = r_s_wdata;
  assign busy       = w_busy;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_arbiter
//  Purpose : Scoreboard bench for mem_arbiter. Two instances (RD_LAT=1 and
//            RD_LAT=2) share stimulus; each has its own SRAM model. Directed
//            stimulus pushes expected grants; a negedge monitor pops and checks
//            S_* per grant and the read returns derived from expected grants.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [2:0]  rreq;
  logic [3:0]  wreq  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];

  wire [2:0]  gnt     [2];
  wire [2:0]  rvalid  [2];
  wire [31:0] rdata   [2][3];
  wire [2:0]  err     [2];
  wire        s_rreq  [2];
  wire [3:0]  s_wreq  [2];
  wire [31:0] s_addr  [2];
  wire [31:0] s_wdata [2];
  wire [31:0] s_rdata [2];
  wire        busy    [2];

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    if (a == 32'h5) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(d + 1)) u_dut (
      .clk(clk), .rst(rst),
      .M0_R_req(rreq[0]), .M0_W_req(wreq[0]), .M0_addr(addr[0]), .M0_W_data(wdata[0]),
      .M0_gnt(gnt[d][0]), .M0_R_valid(rvalid[d][0]), .M0_R_data(rdata[d][0]), .M0_err(err[d][0]),
      .M1_R_req(rreq[1]), .M1_W_req(wreq[1]), .M1_addr(addr[1]), .M1_W_data(wdata[1]),
      .M1_gnt(gnt[d][1]), .M1_R_valid(rvalid[d][1]), .M1_R_data(rdata[d][1]), .M1_err(err[d][1]),
      .M2_R_req(rreq[2]), .M2_W_req(wreq[2]), .M2_addr(addr[2]), .M2_W_data(wdata[2]),
      .M2_gnt(gnt[d][2]), .M2_R_valid(rvalid[d][2]), .M2_R_data(rdata[d][2]), .M2_err(err[d][2]),
      .S_R_req(s_rreq[d]), .S_W_req(s_wreq[d]), .S_addr(s_addr[d]), .S_W_data(s_wdata[d]),
      .S_R_data(s_rdata[d]), .busy(busy[d])
    );

    // SRAM model: data for a read strobe appears d+1 cycles after the strobe.
    logic [3:0]  sv;
    logic [31:0] ah [4];
    always @(posedge clk) begin
      if (!rst) begin
        sv <= '0;
      end else begin
        sv    <= {sv[2:0], s_rreq[d]};
        ah[0] <= s_addr[d];
        for (int k = 1; k < 4; k++) ah[k] <= ah[k-1];
      end
    end
    assign s_rdata[d] = sv[d] ? sram_val(ah[d]) : 32'hBADC0DE0;
  end

  typedef struct { int idx; logic sr; logic [3:0] sw; logic [31:0] a; logic [31:0] wd; } gexp_t;
  typedef struct { int due; int idx; logic [31:0] data; } rexp_t;
  gexp_t gq0[$], gq1[$];
  rexp_t rq0[$], rq1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_g(input int idx, input logic sr, input logic [3:0] sw,
                        input logic [31:0] a, input logic [31:0] wd);
    gexp_t e;
    e.idx = idx; e.sr = sr; e.sw = sw; e.a = a; e.wd = wd;
    gq0.push_back(e);
    gq1.push_back(e);
  endtask

  task automatic flush();
    gq0.delete(); gq1.delete(); rq0.delete(); rq1.delete();
  endtask

  task automatic clear_inputs();
    rreq = '0;
    for (int i = 0; i < 3; i++) begin
      wreq[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
  endtask

  task automatic chk_gnt(input string nm, input logic [2:0] exp);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d %s", d, nm), gnt[d], exp);
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic mon(input int d);
    gexp_t e;
    rexp_t r;
    rexp_t nr;
    logic have;
    logic [2:0] expv;
    have = 1'b0;
    expv = '0;
    if (d == 0) begin
      while (rq0.size() > 0 && rq0[0].due < cyc) begin
        r = rq0.pop_front(); chk("d0 missed read return", 0, 1);
      end
      if (rq0.size() > 0 && rq0[0].due == cyc) begin r = rq0.pop_front(); have = 1'b1; end
    end else begin
      while (rq1.size() > 0 && rq1[0].due < cyc) begin
        r = rq1.pop_front(); chk("d1 missed read return", 0, 1);
      end
      if (rq1.size() > 0 && rq1[0].due == cyc) begin r = rq1.pop_front(); have = 1'b1; end
    end
    if (have) expv = 3'b001 << r.idx;
    chk($sformatf("d%0d R_valid", d), rvalid[d], expv);
    for (int i = 0; i < 3; i++)
      chk($sformatf("d%0d M%0d R_data", d, i), rdata[d][i], (have && r.idx == i) ? r.data : 32'h0);

    chk($sformatf("d%0d gnt onehot", d), $onehot0(gnt[d]), 1);
    if (|gnt[d]) begin
      have = 1'b0;
      if (d == 0 && gq0.size() > 0) begin e = gq0.pop_front(); have = 1'b1; end
      if (d == 1 && gq1.size() > 0) begin e = gq1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk($sformatf("d%0d unexpected gnt", d), gnt[d], 0);
      end else begin
        chk($sformatf("d%0d gnt order", d), gnt[d], 3'b001 << e.idx);
        chk($sformatf("d%0d S_R_req", d), s_rreq[d], e.sr);
        chk($sformatf("d%0d S_W_req", d), s_wreq[d], e.sw);
        chk($sformatf("d%0d S_addr", d), s_addr[d], e.a);
        chk($sformatf("d%0d S_W_data", d), s_wdata[d], e.wd);
        if (e.sr) begin
          nr.due = cyc + d + 1; nr.idx = e.idx; nr.data = sram_val(e.a);
          if (d == 0) rq0.push_back(nr); else rq1.push_back(nr);
        end
      end
    end else begin
      chk($sformatf("d%0d idle S_*", d), {s_rreq[d], s_wreq[d], s_addr[d], s_wdata[d]}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    clear_inputs();
    rst = 1'b0;

    // Single read from M0, request held from reset.
    flush();
    rreq[0] = 1'b1; addr[0] = 32'h5;
    push_g(0, 1'b1, 4'h0, 32'h5, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); chk_gnt("t1 no grant at first edge", 3'b000);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d busy idle", d), busy[d], 1'b0);
    @(negedge clk); chk_gnt("t1 grant at second edge", 3'b001);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d busy gnt", d), busy[d], 1'b1);
    rreq[0] = 1'b0;
    @(negedge clk);
    chk("d0 t1 R_valid", rvalid[0], 3'b001);
    chk("d0 t1 R_data", rdata[0][0], 32'hDEADBEEF);
    @(negedge clk);
    chk("d0 busy after return", busy[0], 1'b0);
    chk("d1 busy in flight", busy[1], 1'b1);
    chk("d1 t1 R_valid", rvalid[1], 3'b001);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d busy done", d), busy[d], 1'b0);

    // M1 and M2 read together.
    rreq[1] = 1'b1; addr[1] = 32'h10;
    rreq[2] = 1'b1; addr[2] = 32'h20;
    push_g(1, 1'b1, 4'h0, 32'h10, 32'h0);
    push_g(2, 1'b1, 4'h0, 32'h20, 32'h0);
    @(negedge clk); chk_gnt("t2 M1 first", 3'b010); rreq[1] = 1'b0;
    @(negedge clk); chk_gnt("t2 M2 next", 3'b100); rreq[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err clear", d), err[d], 3'b000);

    // M2 read+write conflict: executed as write, sticky err.
    rreq[2] = 1'b1; wreq[2] = 4'hF; addr[2] = 32'h30; wdata[2] = 32'h12345678;
    push_g(2, 1'b0, 4'hF, 32'h30, 32'h12345678);
    @(negedge clk); chk_gnt("t3 M2 write", 3'b100);
    clear_inputs();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err set", d), err[d], 3'b100);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err sticky", d), err[d], 3'b100);

    // All three write continuously from reset.
    rst = 1'b0;
    flush();
    wreq[0] = 4'hF; addr[0] = 32'h100; wdata[0] = 32'hA0;
    wreq[1] = 4'h3; addr[1] = 32'h101; wdata[1] = 32'hA1;
    wreq[2] = 4'hC; addr[2] = 32'h102; wdata[2] = 32'hA2;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: push_g(0, 1'b0, 4'hF, 32'h100, 32'hA0);
        1: push_g(1, 1'b0, 4'h3, 32'h101, 32'hA1);
        default: push_g(2, 1'b0, 4'hC, 32'h102, 32'hA2);
      endcase
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err reset", d), err[d], 3'b000);
    #2 rst = 1'b1;
    @(negedge clk); chk_gnt("t4 no grant at first edge", 3'b000);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk_gnt($sformatf("t4 rotation %0d", k), 3'b001 << (k % 3));
    end
    clear_inputs();
    repeat (2) @(negedge clk);

    // Read return coinciding with a write grant.
    rreq[0] = 1'b1; addr[0] = 32'h7;
    wreq[1] = 4'hF; addr[1] = 32'h200; wdata[1] = 32'hCAFE;
    push_g(0, 1'b1, 4'h0, 32'h7, 32'h0);
    push_g(1, 1'b0, 4'hF, 32'h200, 32'hCAFE);
    @(negedge clk); chk_gnt("t5 M0 read", 3'b001); rreq[0] = 1'b0;
    @(negedge clk); chk_gnt("t5 M1 write", 3'b010);
    chk("d0 t5 R_valid with write gnt", rvalid[0], 3'b001);
    wreq[1] = 4'h0;
    repeat (3) @(negedge clk);

    // M0 holds its write after the grant.
    wreq[0] = 4'h1; addr[0] = 32'h300; wdata[0] = 32'h55;
    push_g(0, 1'b0, 4'h1, 32'h300, 32'h55);
    push_g(0, 1'b0, 4'h1, 32'h300, 32'h55);
    @(negedge clk); chk_gnt("t6 first grant", 3'b001);
    @(negedge clk); chk_gnt("t6 no regrant", 3'b000);
    @(negedge clk); chk_gnt("t6 regrant", 3'b001);
    wreq[0] = 4'h0;
    repeat (2) @(negedge clk);

    // Reset one cycle after a read grant.
    rreq[0] = 1'b1; addr[0] = 32'h9;
    push_g(0, 1'b1, 4'h0, 32'h9, 32'h0);
    @(negedge clk); chk_gnt("t7 read grant", 3'b001); rreq[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    flush();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst gnt", d), gnt[d], 3'b000);
      chk($sformatf("d%0d rst R_valid", d), rvalid[d], 3'b000);
      chk($sformatf("d%0d rst R_data", d), {rdata[d][0], rdata[d][1], rdata[d][2]}, 0);
      chk($sformatf("d%0d rst S_*", d), {s_rreq[d], s_wreq[d], s_addr[d], s_wdata[d]}, 0);
      chk($sformatf("d%0d rst busy/err", d), {busy[d], err[d]}, 0);
    end
    wreq[1] = 4'h2; addr[1] = 32'h400; wdata[1] = 32'h77;
    push_g(1, 1'b0, 4'h2, 32'h400, 32'h77);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); chk_gnt("t7 no grant at first edge", 3'b000);
    @(negedge clk); chk_gnt("t7 grant at second edge", 3'b010);
    wreq[1] = 4'h0;
    repeat (5) @(negedge clk);

    chk("gq0 drained", gq0.size(), 0);
    chk("gq1 drained", gq1.size(), 0);
    chk("rq0 drained", rq0.size(), 0);
    chk("rq1 drained", rq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
